ir_nec_tx: RTL and testbench

- Parametrised NEC-protocol infrared transmitter. Successor to the fixed-frame IrDA sender.
- Accepts an NBITS-wide frame word per request through a ready/start handshake. Also sends NEC repeat codes on request.
- Emits an exact-length envelope, a carrier-modulated TXD for the IrDA transceiver, and a one-cycle done pulse.
- Sits between application logic (button/UART command decoder) and the transceiver pins on the 12 MHz icestick.

---
 rtl/ir_nec_tx.sv | 209 ++++++++++++++++++++
 tb/tb_ir_nec_tx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: leader, LSB-first data bits (or repeat code), stop mark,
// with a registered envelope, carrier-modulated txd and a one-cycle done pulse.
module ir_nec_tx #(
   parameter int CARRIER_HALF = 158,
   parameter int AGC_MARK     = 108000,
   parameter int AGC_SPACE    = 54000,
   parameter int RPT_SPACE    = 27000,
   parameter int BIT_MARK     = 6750,
   parameter int ZERO_SPACE   = 6750,
   parameter int ONE_SPACE    = 20250,
   parameter int NBITS        = 32,
   parameter int CARRIER_EN   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             repeat_req,
   input  logic [NBITS-1:0] data,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             envelope,
   output logic             txd,
   output logic             sd
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAX_DUR = max2(max2(max2(AGC_MARK, AGC_SPACE), max2(RPT_SPACE, BIT_MARK)),
                                 max2(ZERO_SPACE, ONE_SPACE));
   localparam int CW = $clog2(MAX_DUR + 1);
   localparam int BW = $clog2(NBITS + 1);
   localparam int PW = $clog2(2 * CARRIER_HALF + 1);

   // Counter reload values are duration-1: the state is left when the counter reads zero.
   localparam logic [CW-1:0] LD_AGC_MARK   = CW'(AGC_MARK - 1);
   localparam logic [CW-1:0] LD_AGC_SPACE  = CW'(AGC_SPACE - 1);
   localparam logic [CW-1:0] LD_RPT_SPACE  = CW'(RPT_SPACE - 1);
   localparam logic [CW-1:0] LD_BIT_MARK   = CW'(BIT_MARK - 1);
   localparam logic [CW-1:0] LD_ZERO_SPACE = CW'(ZERO_SPACE - 1);
   localparam logic [CW-1:0] LD_ONE_SPACE  = CW'(ONE_SPACE - 1);
   localparam logic [BW-1:0] BIDX_LAST     = BW'(NBITS - 1);
   localparam logic [PW-1:0] PH_LAST       = PW'(2 * CARRIER_HALF - 1);
   localparam logic [PW-1:0] PH_HALF       = PW'(CARRIER_HALF);

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK_S,
      BIT_SPACE_S,
      STOP_MARK
   } state_e;

   typedef enum logic {
      MODE_DATA,
      MODE_RPT
   } mode_e;

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [NBITS-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bidx_q, bidx_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             env_q, env_d;
   logic             txd_q, txd_d;
   logic             sd_q, sd_d;
   logic             cnt_zero;

   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      bidx_d  = bidx_q;
      done_d  = 1'b0;
      phase_d = '0;
      env_d   = 1'b0;
      txd_d   = 1'b0;
      sd_d    = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               shreg_d = data;
               mode_d  = MODE_DATA;
               bidx_d  = '0;
               state_d = LEAD_MARK;
               cnt_d   = LD_AGC_MARK;
            end else if (repeat_req) begin
               mode_d  = MODE_RPT;
               bidx_d  = '0;
               state_d = LEAD_MARK;
               cnt_d   = LD_AGC_MARK;
            end
         end
         LEAD_MARK: begin
            if (cnt_zero) begin
               state_d = LEAD_SPACE;
               cnt_d   = (mode_q == MODE_RPT) ? LD_RPT_SPACE : LD_AGC_SPACE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         LEAD_SPACE: begin
            if (cnt_zero) begin
               state_d = (mode_q == MODE_RPT) ? STOP_MARK : BIT_MARK_S;
               cnt_d   = LD_BIT_MARK;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         BIT_MARK_S: begin
            if (cnt_zero) begin
               state_d = BIT_SPACE_S;
               cnt_d   = shreg_q[0] ? LD_ONE_SPACE : LD_ZERO_SPACE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         BIT_SPACE_S: begin
            if (cnt_zero) begin
               shreg_d = shreg_q >> 1;
               bidx_d  = bidx_q + 1'b1;
               state_d = (bidx_q == BIDX_LAST) ? STOP_MARK : BIT_MARK_S;
               cnt_d   = LD_BIT_MARK;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         STOP_MARK: begin
            if (cnt_zero) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      env_d = (state_d == LEAD_MARK) || (state_d == BIT_MARK_S) || (state_d == STOP_MARK);

      // Carrier phase restarts on every mark entry so each mark opens with a high half.
      if (env_d && (state_d == state_q)) begin
         phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      end

      if (CARRIER_EN != 0) begin
         txd_d = env_d && (phase_d < PH_HALF);
      end else begin
         txd_d = env_d;
      end

      ready_d = (state_d == IDLE);
      busy_d  = ~ready_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= MODE_DATA;
         cnt_q   <= '0;
         shreg_q <= '0;
         bidx_q  <= '0;
         phase_q <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         env_q   <= 1'b0;
         txd_q   <= 1'b0;
         sd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         bidx_q  <= bidx_d;
         phase_q <= phase_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         env_q   <= env_d;
         txd_q   <= txd_d;
         sd_q    <= sd_d;
      end
   end

   assign ready    = ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign envelope = env_q;
   assign txd      = txd_q;
   assign sd       = sd_q;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Scoreboard bench for ir_nec_tx: requests queue expected frames, a monitor rebuilds each
// frame's envelope/txd from NEC timing rules and compares when done pulses.
module tb_ir_nec_tx;

   localparam int CH = 2;
   localparam int AM = 16;
   localparam int AS = 8;
   localparam int RS = 4;
   localparam int BM = 2;
   localparam int ZS = 2;
   localparam int OS = 6;
   localparam int NB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          repeat_req;
   logic [NB-1:0] data;
   logic ready, busy, done, envelope, txd, sd;
   logic nc_ready, nc_busy, nc_done, nc_envelope, nc_txd, nc_sd;

   ir_nec_tx #(
      .CARRIER_HALF(CH), .AGC_MARK(AM), .AGC_SPACE(AS), .RPT_SPACE(RS),
      .BIT_MARK(BM), .ZERO_SPACE(ZS), .ONE_SPACE(OS), .NBITS(NB), .CARRIER_EN(1)
   ) u_dut (
      .clk(clk), .rst(rst), .start(start), .repeat_req(repeat_req), .data(data),
      .ready(ready), .busy(busy), .done(done), .envelope(envelope), .txd(txd), .sd(sd)
   );

   ir_nec_tx #(
      .CARRIER_HALF(CH), .AGC_MARK(AM), .AGC_SPACE(AS), .RPT_SPACE(RS),
      .BIT_MARK(BM), .ZERO_SPACE(ZS), .ONE_SPACE(OS), .NBITS(NB), .CARRIER_EN(0)
   ) u_dut_nc (
      .clk(clk), .rst(rst), .start(start), .repeat_req(repeat_req), .data(data),
      .ready(nc_ready), .busy(nc_busy), .done(nc_done), .envelope(nc_envelope),
      .txd(nc_txd), .sd(nc_sd)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            rpt;
      logic [NB-1:0] d;
   } req_t;

   req_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   bit   exp_env[$];
   bit   exp_txd[$];
   bit   rec_env[$];
   bit   rec_txd[$];
   bit   recording = 0;
   bit   prev_done = 0;
   int   nc_bad    = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      failures++;
      $display("FAIL %s: %s", name, what);
   endtask

   // Reference: a frame is a list of (level, length) segments; the carrier is high for the
   // first CH cycles of every 2*CH cycles counted from the start of each mark.
   task automatic add_seg(input bit lvl, input int len);
      for (int i = 0; i < len; i++) begin
         exp_env.push_back(lvl);
         exp_txd.push_back(lvl && ((i % (2 * CH)) < CH));
      end
   endtask

   task automatic build_expected(input req_t r);
      exp_env.delete();
      exp_txd.delete();
      add_seg(1'b1, AM);
      add_seg(1'b0, r.rpt ? RS : AS);
      if (!r.rpt) begin
         for (int b = 0; b < NB; b++) begin
            add_seg(1'b1, BM);
            add_seg(1'b0, r.d[b] ? OS : ZS);
         end
      end
      add_seg(1'b1, BM);
   endtask

   initial begin : monitor
      req_t r;
      int   em;
      int   tm;
      forever begin
         @(negedge clk);
         if (rst) begin
            recording = 0;
            prev_done = 0;
            nc_bad    = 0;
            rec_env.delete();
            rec_txd.delete();
         end else begin
            if (prev_done) chk("done_width", done, 0);
            if (!recording && envelope) begin
               recording = 1;
               nc_bad    = 0;
               rec_env.delete();
               rec_txd.delete();
            end
            if (recording && !done) begin
               rec_env.push_back(envelope);
               rec_txd.push_back(txd);
               if (nc_txd !== nc_envelope || nc_envelope !== envelope || nc_done !== done)
                  nc_bad++;
               if (rec_env.size() > 400) begin
                  fail_now("frame_timeout", "no done within 400 cycles of envelope rise");
                  recording = 0;
               end
            end
            if (done) begin
               if (sb.size() == 0) begin
                  fail_now("unexpected_done", "done pulsed with no frame pending");
               end else begin
                  r = sb.pop_front();
                  build_expected(r);
                  em = 0;
                  tm = 0;
                  for (int i = 0; i < exp_env.size(); i++) begin
                     if (i >= rec_env.size()) begin
                        em++;
                        tm++;
                     end else begin
                        if (rec_env[i] != exp_env[i]) em++;
                        if (rec_txd[i] != exp_txd[i]) tm++;
                     end
                  end
                  chk("frame_len", rec_env.size(), exp_env.size());
                  chk("env_shape_mismatches", em, 0);
                  chk("txd_carrier_mismatches", tm, 0);
                  chk("nc_txd_vs_env_mismatches", nc_bad, 0);
                  chk("nc_done", nc_done, 1);
                  chk("ready_at_done", ready, 1);
                  chk("busy_at_done", busy, 0);
               end
               recording = 0;
               nc_bad    = 0;
               rec_env.delete();
               rec_txd.delete();
            end
            prev_done = done;
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!ready) fail_now("wait_ready", "ready=0 after 300 cycles, expected 1");
   endtask

   task automatic issue(input bit s, input bit r, input logic [NB-1:0] d);
      req_t q;
      start      = s;
      repeat_req = r;
      data       = d;
      q.rpt = !s;
      q.d   = d;
      if (s || r) sb.push_back(q);
      @(negedge clk);
      start      = 1'b0;
      repeat_req = 1'b0;
      data       = NB'($urandom);
   endtask

   task automatic run_frame(input bit s, input bit r, input logic [NB-1:0] d, input bit noisy);
      int n = 0;
      wait_ready();
      issue(s, r, d);
      while (!ready && n < 300) begin
         data = NB'($urandom);
         if (noisy) begin
            start      = ($urandom_range(0, 3) == 0);
            repeat_req = ($urandom_range(0, 3) == 0);
         end
         @(negedge clk);
         n++;
      end
      start      = 1'b0;
      repeat_req = 1'b0;
      if (!ready) fail_now("frame_end", "ready=0 after 300 cycles, expected 1");
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      req_t          q;
      int            n;
      int            dn;
      logic [NB-1:0] d;
      rst        = 1'b1;
      start      = 1'b0;
      repeat_req = 1'b0;
      data       = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_envelope", envelope, 0);
      chk("rst_txd", txd, 0);
      chk("rst_sd", sd, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", ready, 1);

      // directed data frame, repeat code, simultaneous requests
      run_frame(1'b1, 1'b0, 4'b0101, 1'b0);
      run_frame(1'b0, 1'b1, 4'b0000, 1'b0);
      run_frame(1'b1, 1'b1, 4'b1100, 1'b0);
      run_frame(1'b1, 1'b0, 4'b1111, 1'b1);
      run_frame(1'b0, 1'b1, 4'b0000, 1'b1);

      // back-to-back: start held across done, second frame takes data from the done cycle
      wait_ready();
      start = 1'b1;
      data  = 4'b0011;
      q.rpt = 1'b0;
      q.d   = 4'b0011;
      sb.push_back(q);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!done) data = NB'($urandom);
      end while (!done && n < 300);
      if (!done) begin
         fail_now("b2b_done", "no done within 300 cycles");
      end else begin
         d     = NB'($urandom);
         data  = d;
         q.d   = d;
         sb.push_back(q);
         @(negedge clk);
         chk("b2b_envelope_rise", envelope, 1);
         chk("b2b_busy", busy, 1);
      end
      start = 1'b0;
      run_frame(1'b0, 1'b0, 4'b0000, 1'b1);

      // randomized mix
      for (int k = 0; k < 12; k++) begin
         int kind;
         kind = $urandom_range(0, 3);
         d    = NB'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         case (kind)
            0:       run_frame(1'b1, 1'b0, d, 1'b0);
            1:       run_frame(1'b0, 1'b1, d, 1'b1);
            2:       run_frame(1'b1, 1'b1, d, 1'b0);
            default: run_frame(1'b1, 1'b0, d, 1'b1);
         endcase
      end

      // reset in the first bit space (bit 0 = 1 makes it six cycles long)
      wait_ready();
      d = NB'($urandom) | 4'b0001;
      issue(1'b1, 1'b0, d);
      n = 0;
      while (!envelope && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!envelope) fail_now("abort_env_rise", "envelope never rose");
      repeat (27) @(negedge clk);
      chk("abort_in_space_env", envelope, 0);
      chk("abort_in_space_busy", busy, 1);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("abort_envelope", envelope, 0);
      chk("abort_txd", txd, 0);
      chk("abort_ready", ready, 1);
      chk("abort_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      dn  = 0;
      repeat (80) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("abort_no_done", dn, 0);
      run_frame(1'b1, 1'b0, 4'b1010, 1'b0);

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      chk("monitor_idle", recording, 0);
      chk("final_sd", sd, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
